// File: rtl/exu_mdu.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Optional build macro MDU_FAST_MUL_EN: single-cycle multiplies, division stays iterative.
module exu_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       func_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             func_q, func_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic                   neg_q, neg_d;
  logic                   rem_neg_q, rem_neg_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   out_valid_q, out_valid_d;

  logic                   sign1_en, sign2_en, s1_neg, s2_neg;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic                   div_zero, div_ovf;
  logic [WIDTH-1:0]       special_res;
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_next;
  logic [WIDTH:0]         div_sh, div_diff;
  logic                   q_ok;
  logic [2*WIDTH-1:0]     div_next, step_next, prod;
  logic [WIDTH-1:0]       quo, rem, calc_res;

  function automatic logic [WIDTH-1:0] mul_pick(input logic [2:0] f,
                                                input logic [2*WIDTH-1:0] p);
    mul_pick = (f == 3'd0) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
  endfunction

  // Operand decode at accept: MUL/MULH/MULHSU/DIV/REM sign src1; MUL/MULH/DIV/REM sign src2.
  always_comb begin
    sign1_en    = (func_i == 3'd0) || (func_i == 3'd1) || (func_i == 3'd2) ||
                  (func_i == 3'd4) || (func_i == 3'd6);
    sign2_en    = (func_i == 3'd0) || (func_i == 3'd1) || (func_i == 3'd4) || (func_i == 3'd6);
    s1_neg      = sign1_en && src1_i[WIDTH-1];
    s2_neg      = sign2_en && src2_i[WIDTH-1];
    a_mag       = s1_neg ? (~src1_i + 1'b1) : src1_i;
    b_mag       = s2_neg ? (~src2_i + 1'b1) : src2_i;
    div_zero    = func_i[2] && (src2_i == '0);
    div_ovf     = func_i[2] && !func_i[0] && (src2_i == '1) &&
                  (src1_i == {1'b1, {(WIDTH-1){1'b0}}});
    special_res = '0;
    if (div_zero) special_res = func_i[1] ? src1_i : '1;
    else if (div_ovf) special_res = func_i[1] ? '0 : src1_i;
  end

  // One iteration step from the registered accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : '0)};
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_sh    = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_sh - {1'b0, b_q};
    q_ok      = !div_diff[WIDTH];
    div_next  = {(q_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], q_ok};
    step_next = func_q[2] ? div_next : mul_next;
    prod      = neg_q ? (~step_next + 1'b1) : step_next;
    quo       = step_next[WIDTH-1:0];
    rem       = step_next[2*WIDTH-1:WIDTH];
    case (func_q)
      3'd4:    calc_res = neg_q ? (~quo + 1'b1) : quo;
      3'd5:    calc_res = quo;
      3'd6:    calc_res = rem_neg_q ? (~rem + 1'b1) : rem;
      3'd7:    calc_res = rem;
      default: calc_res = mul_pick(func_q, prod);
    endcase
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_mag, fast_prod;
  always_comb begin
    fast_mag  = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    fast_prod = (s1_neg ^ s2_neg) ? (~fast_mag + 1'b1) : fast_mag;
  end
`endif

  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result_q;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            func_d    = func_i;
            a_d       = a_mag;
            b_d       = b_mag;
            neg_d     = s1_neg ^ s2_neg;
            rem_neg_d = s1_neg;
            cnt_d     = CntW'(WIDTH - 1);
            // Divide seeds the dividend; multiply seeds the multiplier in the low half.
            acc_d     = {{WIDTH{1'b0}}, (func_i[2] ? a_mag : b_mag)};
            if (div_zero || div_ovf) begin
              result_d = special_res;
              state_d  = StDone;
`ifdef MDU_FAST_MUL_EN
            end else if (!func_i[2]) begin
              result_d = mul_pick(func_i, fast_prod);
              state_d  = StDone;
`endif
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          acc_d = step_next;
          if (cnt_q == '0) begin
            result_d = calc_res;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (out_ready_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
    out_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      func_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      func_q      <= func_d;
      a_q         <= a_d;
      b_q         <= b_d;
      neg_q       <= neg_d;
      rem_neg_q   <= rem_neg_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;

endmodule

// File: tb/tb_exu_mdu.sv
// Directed bench for exu_mdu: vector table plus backpressure, flush and reset sequences.
module tb_exu_mdu;

`ifdef MDU_FAST_MUL_EN
  localparam int MulLat = 0;
`else
  localparam int MulLat = 32;
`endif
  localparam int DivLat = 32;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  func_i = 3'd0;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] result_o;
  logic        busy_o;

  int compared = 0;
  int mismatched = 0;

  exu_mdu #(.WIDTH(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .func_i      (func_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Accept one op, wait for out_valid; lat counts edges after the accept edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    func_i     = f;
    src1_i     = a;
    src2_i     = b;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    func_i     = 3'($urandom);
    src1_i     = $urandom;
    src2_i     = $urandom;
    lat = 0;
    while (out_valid_o !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int elat);
    int lat;
    check({tag, " in_ready before"}, {31'd0, in_ready_o}, 32'd1);
    issue(f, a, b, lat);
    check({tag, " latency"}, lat, elat);
    check({tag, " result"}, result_o, exp);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check({tag, " in_ready after"}, {31'd0, in_ready_o}, 32'd1);
  endtask

  initial begin
    int lat;
    vecs.push_back('{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MulLat});
    vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MulLat});
    vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MulLat});
    vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MulLat});
    vecs.push_back('{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, MulLat});
    vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MulLat});
    vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DivLat});
    vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DivLat});
    vecs.push_back('{3'd5, 32'd100,      32'd7,        32'd14,       DivLat});
    vecs.push_back('{3'd7, 32'd100,      32'd7,        32'd2,        DivLat});
    vecs.push_back('{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DivLat});
    vecs.push_back('{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        DivLat});
    vecs.push_back('{3'd4, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, DivLat});
    vecs.push_back('{3'd6, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, DivLat});
    vecs.push_back('{3'd5, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, DivLat});
    vecs.push_back('{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 0});
    vecs.push_back('{3'd7, 32'd5,        32'd0,        32'd5,        0});
    vecs.push_back('{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 0});
    vecs.push_back('{3'd6, 32'd5,        32'd0,        32'd5,        0});
    vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0});
    vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0});

    #2;
    check("reset in_ready", {31'd0, in_ready_o}, 32'd1);
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset out_valid", {31'd0, out_valid_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();

    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Backpressure: hold DONE for 10 cycles.
    issue(3'd5, 32'd100, 32'd7, lat);
    check("bp latency", lat, DivLat);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp result c%0d", i), result_o, 32'd14);
      check($sformatf("bp in_ready c%0d", i), {31'd0, in_ready_o}, 32'd0);
      check($sformatf("bp busy c%0d", i), {31'd0, busy_o}, 32'd1);
      check($sformatf("bp out_valid c%0d", i), {31'd0, out_valid_o}, 32'd1);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("bp in_ready after", {31'd0, in_ready_o}, 32'd1);
    check("bp out_valid after", {31'd0, out_valid_o}, 32'd0);

    // Flush on the 5th CALC cycle.
    func_i = 3'd4; src1_i = 32'd1000; src2_i = 32'd3; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    check("flush busy in calc", {31'd0, busy_o}, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush in_ready", {31'd0, in_ready_o}, 32'd1);
    check("flush busy", {31'd0, busy_o}, 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (out_valid_o === 1'b1) seen++;
        tick();
      end
      check("flush out_valid never", seen, 0);
    end
    check("flush result kept", result_o, 32'd14);

    // Accept coinciding with flush is dropped.
    func_i = 3'd4; src1_i = 32'd5; src2_i = 32'd0; in_valid_i = 1'b1; flush_i = 1'b1;
    tick();
    in_valid_i = 1'b0; flush_i = 1'b0;
    check("flush+accept busy", {31'd0, busy_o}, 32'd0);
    check("flush+accept out_valid", {31'd0, out_valid_o}, 32'd0);

    // Async reset mid-DIV.
    func_i = 3'd4; src1_i = 32'd1000; src2_i = 32'd3; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_i = 1'b1;
    #1;
    check("rst in_ready", {31'd0, in_ready_o}, 32'd1);
    check("rst busy", {31'd0, busy_o}, 32'd0);
    check("rst out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst result", result_o, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    do_op("post-rst mul", 3'd0, 32'd3, 32'd4, 32'd12, MulLat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
